// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core load/store path and the DMA/loader.
// Core wins by default; a starvation counter and a DMA lock mode guarantee DMA progress.
module dmem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  input  logic [3:0]    core_mask,
  output logic          core_gnt,
  output logic          core_stall,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic [3:0]    dma_mask,
  input  logic          dma_lock,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_mask,
  input  logic [DW-1:0] mem_rdata
);

  localparam int            CW        = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT     = CW'(STARVE_LIMIT);
  localparam logic [0:0]    ST_OPEN   = 1'b0;
  localparam logic [0:0]    ST_LOCKED = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          resp_pending_q, resp_pending_d;
  logic          resp_owner_q, resp_owner_d;  // 1 = DMA owns the pending read

  // Grants are gated by rst so every output reads 0 while reset is held.
  always_comb begin
    core_gnt = 1'b0;
    dma_gnt  = 1'b0;
    if (rst) begin
      if (state_q == ST_LOCKED && dma_req) begin
        dma_gnt = 1'b1;
      end else if (dma_req && (!core_req || starve_cnt_q == LIMIT)) begin
        dma_gnt = 1'b1;
      end else if (core_req) begin
        core_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = (dma_gnt && dma_lock) ? ST_LOCKED : ST_OPEN;
    if (dma_req && !dma_gnt) begin
      starve_cnt_d = (starve_cnt_q == LIMIT) ? LIMIT : starve_cnt_q + 1'b1;
    end else begin
      starve_cnt_d = '0;
    end
    resp_pending_d = mem_en && !mem_we;
    resp_owner_d   = dma_gnt;
  end

  always_comb begin
    mem_en    = core_gnt | dma_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_mask  = '0;
    if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      mem_mask  = core_mask;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_mask  = dma_mask;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_OPEN;
      starve_cnt_q   <= '0;
      resp_pending_q <= 1'b0;
      resp_owner_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      starve_cnt_q   <= starve_cnt_d;
      resp_pending_q <= resp_pending_d;
      resp_owner_q   <= resp_owner_d;
    end
  end

  assign core_stall  = rst & core_req & ~core_gnt;
  assign core_rvalid = resp_pending_q & ~resp_owner_q;
  assign dma_rvalid  = resp_pending_q & resp_owner_q;
  assign core_rdata  = core_rvalid ? mem_rdata : '0;
  assign dma_rdata   = dma_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: reset, directed table, corner sequences and
// randomized traffic compared against a request/wait-count reference model.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic          core_req = 0, core_we = 0, dma_req = 0, dma_we = 0, dma_lock = 0;
  logic [AW-1:0] core_addr = 0, dma_addr = 0;
  logic [DW-1:0] core_wdata = 0, dma_wdata = 0, mem_rdata = 0;
  logic [3:0]    core_mask = 0, dma_mask = 0;

  logic          core_gnt, core_stall, core_rvalid, dma_gnt, dma_rvalid, mem_en, mem_we;
  logic [DW-1:0] core_rdata, dma_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_mask;

  logic          core_gnt_b, core_stall_b, core_rvalid_b, dma_gnt_b, dma_rvalid_b, mem_en_b, mem_we_b;
  logic [DW-1:0] core_rdata_b, dma_rdata_b, mem_wdata_b;
  logic [AW-1:0] mem_addr_b;
  logic [3:0]    mem_mask_b;

  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) u_dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_mask(core_mask), .core_gnt(core_gnt), .core_stall(core_stall),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_mask(dma_mask), .dma_lock(dma_lock), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mask(mem_mask), .mem_rdata(mem_rdata)
  );

  // Second instance exercises the smallest starvation limit on the same stimulus.
  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(1)) u_dut_lim1 (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_mask(core_mask), .core_gnt(core_gnt_b), .core_stall(core_stall_b),
    .core_rvalid(core_rvalid_b), .core_rdata(core_rdata_b),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_mask(dma_mask), .dma_lock(dma_lock), .dma_gnt(dma_gnt_b),
    .dma_rvalid(dma_rvalid_b), .dma_rdata(dma_rdata_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_mask(mem_mask_b), .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: DMA wait count, lock flag and one-deep read response.
  bit m_locked, m_pend, m_owner_dma;
  int m_wait;
  bit g_core, g_dma;

  typedef struct {
    logic c_req, d_req, d_lock, e_cgnt, e_dgnt, e_stall;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_pend = 0; m_owner_dma = 0; m_wait = 0; g_core = 0; g_dma = 0;
  endtask

  // Called once per cycle at the falling edge: compare every output, then advance the model.
  task automatic check_all();
    bit eg_d, eg_c;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    logic [3:0] em;
    logic ewe;
    eg_d = dma_req && (m_locked || !core_req || m_wait >= LIMIT);
    eg_c = core_req && !eg_d;
    ewe = eg_c ? core_we : (eg_d ? dma_we : 1'b0);
    ea  = eg_c ? core_addr : (eg_d ? dma_addr : '0);
    ew  = eg_c ? core_wdata : (eg_d ? dma_wdata : '0);
    em  = eg_c ? core_mask : (eg_d ? dma_mask : '0);
    chk("core_gnt", core_gnt, eg_c);
    chk("dma_gnt", dma_gnt, eg_d);
    chk("core_stall", core_stall, core_req && !eg_c);
    chk("mem_en", mem_en, eg_c || eg_d);
    chk("mem_we", mem_we, ewe);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ew);
    chk("mem_mask", mem_mask, em);
    chk("core_rvalid", core_rvalid, m_pend && !m_owner_dma);
    chk("dma_rvalid", dma_rvalid, m_pend && m_owner_dma);
    chk("core_rdata", core_rdata, (m_pend && !m_owner_dma) ? mem_rdata : '0);
    chk("dma_rdata", dma_rdata, (m_pend && m_owner_dma) ? mem_rdata : '0);
    if (eg_c || eg_d)
      $display("cyc %0d: %s %s addr=%08h", cyc, eg_c ? "core" : "dma ", ewe ? "WR" : "RD", ea);
    m_locked    = eg_d && dma_lock;
    m_wait      = (dma_req && !eg_d) ? ((m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1) : 0;
    m_pend      = (eg_c || eg_d) && !ewe;
    m_owner_dma = eg_d;
    g_core = eg_c;
    g_dma  = eg_d;
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input bit check_outs);
    rst = 1'b0;
    @(posedge clk);
    #1;
    if (check_outs) begin
      chk("rst_ctrl_outs", {core_gnt, core_stall, core_rvalid, dma_gnt, dma_rvalid, mem_en, mem_we}, '0);
      chk("rst_mem_addr", mem_addr, '0);
      chk("rst_mem_wdata", mem_wdata, '0);
      chk("rst_mem_mask", mem_mask, '0);
      chk("rst_rdata", {core_rdata, dma_rdata}, '0);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int beat;
    // Reset with every request asserted and non-zero attributes.
    core_req = 1; dma_req = 1; core_we = 1; dma_we = 1;
    core_addr = 32'h44; core_wdata = 32'hA5A5; core_mask = 4'hF;
    dma_addr = 32'h88; dma_wdata = 32'h5A5A; dma_mask = 4'h3; mem_rdata = 32'hCAFEF00D;
    do_reset(1'b1);

    // Starvation with STARVE_LIMIT=1: DMA wins every second cycle.
    dma_lock = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lim1_dma_gnt", dma_gnt_b, (i % 2) == 1);
      chk("lim1_core_gnt", core_gnt_b, (i % 2) == 0);
      check_all();
      @(posedge clk); #1; cyc++;
    end

    // Table: contention, forced DMA + lock, lock burst, idle-DMA exit from lock.
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) tbl[i] = '{1, 1, 1, 1, 0, 0};
    tbl[8]  = '{1, 1, 1, 0, 1, 1};
    tbl[9]  = '{1, 1, 1, 0, 1, 1};
    tbl[10] = '{1, 1, 0, 0, 1, 1};
    tbl[11] = '{1, 0, 0, 1, 0, 0};
    tbl[12] = '{0, 1, 1, 0, 1, 0};
    tbl[13] = '{1, 0, 0, 1, 0, 0};
    tbl[14] = '{1, 1, 0, 1, 0, 0};
    beat = 0;
    for (int i = 0; i < 15; i++) begin
      core_req = tbl[i].c_req; dma_req = tbl[i].d_req; dma_lock = tbl[i].d_lock;
      core_we = 1; dma_we = 1; dma_addr = 32'(beat * 4);
      @(negedge clk);
      chk("tbl_core_gnt", core_gnt, tbl[i].e_cgnt);
      chk("tbl_dma_gnt", dma_gnt, tbl[i].e_dgnt);
      chk("tbl_core_stall", core_stall, tbl[i].e_stall);
      check_all();
      if (g_dma) beat++;
      @(posedge clk); #1; cyc++;
    end

    // Core read 0x100, then DMA read 0x20 on the following cycle.
    core_req = 1; core_we = 0; core_addr = 32'h100; dma_req = 0; dma_lock = 0;
    @(negedge clk);
    chk("rd_core_gnt", core_gnt, 1);
    chk("rd_mem_addr", mem_addr, 32'h100);
    chk("rd_mem_en", mem_en, 1);
    check_all();
    @(posedge clk); #1; cyc++;
    core_req = 0; dma_req = 1; dma_we = 0; dma_addr = 32'h20; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("rd_core_rvalid", core_rvalid, 1);
    chk("rd_core_rdata", core_rdata, 32'hDEADBEEF);
    chk("rd_dma_rvalid0", dma_rvalid, 0);
    check_all();
    @(posedge clk); #1; cyc++;
    dma_req = 0; mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("rd_dma_rvalid", dma_rvalid, 1);
    chk("rd_dma_rdata", dma_rdata, 32'h12345678);
    chk("rd_core_rvalid0", core_rvalid, 0);
    check_all();
    @(posedge clk); #1; cyc++;
    tick();

    // Locked DMA read, then reset before its response cycle completes.
    core_req = 0; dma_req = 1; dma_we = 0; dma_lock = 1; dma_addr = 32'h40;
    tick();
    dma_req = 0; mem_rdata = 32'h0BADF00D;
    rst = 1'b0;
    #1;
    chk("rstmid_dma_rvalid", dma_rvalid, 0);
    chk("rstmid_dma_rdata", dma_rdata, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    core_req = 1; core_we = 1; dma_req = 1; dma_lock = 0; dma_we = 1;
    @(negedge clk);
    chk("rstmid_unlocked_core_gnt", core_gnt, 1);
    chk("rstmid_no_rvalid", {core_rvalid, dma_rvalid}, 0);
    check_all();
    @(posedge clk); #1; cyc++;

    // Randomized traffic honouring the hold-until-grant handshake.
    do_reset(1'b0);
    core_req = 0; dma_req = 0;
    for (int i = 0; i < 400; i++) begin
      if (!(core_req && !g_core)) begin
        core_req = ($urandom_range(0, 3) != 0);
        core_we = $urandom_range(0, 1); core_addr = $urandom; core_wdata = $urandom;
        core_mask = 4'($urandom);
      end
      if (!(dma_req && !g_dma)) begin
        dma_req = ($urandom_range(0, 3) != 0);
        dma_we = $urandom_range(0, 1); dma_addr = $urandom; dma_wdata = $urandom;
        dma_mask = 4'($urandom); dma_lock = ($urandom_range(0, 2) == 0);
      end
      mem_rdata = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the core load/store path and a DMA/program-loader master.
- Sits between the data_path memory interface, the loader, and the data memory macro.
- The core has priority by default; a starvation counter guarantees DMA forward progress.
- A lock mode lets the DMA hold the port for back-to-back bursts.
- Drives a stall to the core when the core's access is not granted.

Parameters:
AW, 32, address width
DW, 32, data width
STARVE_LIMIT, 8, consecutive denied DMA request cycles before the DMA is forced ahead of the core (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
core_req  input  1  core memory request
core_we  input  1  core write enable
core_addr  input  AW  core address
core_wdata  input  DW  core write data
core_mask  input  4  core byte mask
core_gnt  output  1  core request accepted this cycle
core_stall  output  1  core_req & ~core_gnt; freezes the core PC/writeback
core_rvalid  output  1  read data valid for core
core_rdata  output  DW  read data to core
dma_req  input  1  DMA request
dma_we  input  1  DMA write enable
dma_addr  input  AW  DMA address
dma_wdata  input  DW  DMA write data
dma_mask  input  4  DMA byte mask
dma_lock  input  1  keep ownership after this transfer
dma_gnt  output  1  DMA request accepted this cycle
dma_rvalid  output  1  read data valid for DMA
dma_rdata  output  DW  read data to DMA
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_mask  output  4  memory byte mask
mem_rdata  input  DW  memory read data, valid 1 cycle after a read strobe

Behaviour:
- Reset (rst=0, async): state=OPEN, starve_cnt=0, resp_pending=0. All outputs 0.
- States:
  - OPEN: normal arbitration.
  - DMA_LOCKED: DMA owns the port.
- Requester handshake:
  - A requester holds req and its attributes stable until gnt.
  - gnt is combinational in the same cycle; that cycle is the transfer.
  - A new request may be granted every cycle.
- OPEN arbitration per cycle:
  - Only one requester active: grant it.
  - Both active and starve_cnt < STARVE_LIMIT: grant core.
  - Both active and starve_cnt == STARVE_LIMIT: grant DMA.
  - DMA granted with dma_lock=1: next state DMA_LOCKED.
- DMA_LOCKED:
  - Core is never granted.
  - dma_req=1: DMA granted.
  - Exit to OPEN after the cycle in which the DMA is granted with dma_lock=0, or any cycle with dma_req=0. In the dma_req=0 cycle the core may be granted (OPEN rules apply combinationally).
- starve_cnt:
  - Increments each cycle dma_req=1 and dma_gnt=0, saturating at STARVE_LIMIT.
  - Clears on dma_gnt=1 or dma_req=0.
- Memory mux:
  - mem_en = core_gnt | dma_gnt (never both).
  - mem_we/addr/wdata/mask come from the granted requester; all 0 when no grant.
- Read response:
  - A granted read (we=0) sets resp_pending=1 and resp_owner=granted side.
  - Next cycle: <owner>_rvalid=1 and <owner>_rdata=mem_rdata. The other side sees rvalid=0 and rdata=0.
  - Writes produce no rvalid.
  - Back-to-back reads to alternating owners are supported: the response register updates every cycle.
- core_stall is purely combinational: core_req & ~core_gnt.
- Boundary conditions:
  - Simultaneous lock request and starvation force: DMA is granted and the lock is taken.
  - Reset asserted mid-read drops the pending response; no rvalid after reset release.
  - STARVE_LIMIT=1: DMA is forced after a single denied cycle.
- Latency:
  - Grant: 0 cycles.
  - Read data: 1 cycle after grant.
  - Maximum DMA wait while core saturates the port: STARVE_LIMIT cycles.

Test Plan:
- Reset: rst=0 with all reqs=1 -> every output 0. Release rst -> arbitration starts next edge.
- Core only: read addr 0x100, mem returns 0xDEADBEEF -> core_gnt same cycle, mem_en=1, mem_addr=0x100. Next cycle core_rvalid=1, core_rdata=0xDEADBEEF, dma_rvalid=0.
- Contention/starvation: core_req and dma_req held high continuously, STARVE_LIMIT=8 -> core granted cycles 0-7, dma_gnt=1 on cycle 8, core_stall=1 on cycle 8, starve_cnt back to 0 on cycle 9.
- Lock burst: DMA writes 0x0,0x4,0x8 with dma_lock=1,1,0 while core_req=1 -> three consecutive dma_gnt; core_stall=1 for 3 cycles; core_gnt on the 4th cycle.
- Interleaved reads: core read 0x10, then DMA read 0x20 on the next cycle -> core_rvalid the cycle after the first grant, dma_rvalid the cycle after the second grant, each with the correct mem_rdata.
- Async reset mid-operation: assert rst=0 between a read grant and its response -> no rvalid appears; state returns to OPEN; lock cleared.
